// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared state encoding, Punto Banco constants and card helpers
package baccarat_pkg;
  typedef enum logic [3:0] {
    DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK1, DEAL_P3, CHECK2, DEAL_D3, DONE
  } state_t;
  typedef struct packed {
    logic p1, p2, p3, d1, d2, d3;
  } loads_t;
  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] BANKER_STAND    = 4'd7;
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd0 : rank;
  endfunction
  function automatic loads_t loads_of(input state_t s);
    return {s == DEAL_P1, s == DEAL_P2, s == DEAL_P3, s == DEAL_D1, s == DEAL_D2, s == DEAL_D3};
  endfunction
endpackage

// File: rtl/baccarat_controller_if.sv
// baccarat_if: score readback and load/light signals between controller and datapath
interface baccarat_if;
  logic [3:0] pscore, dscore, pcard3;
  logic load_pcard1, load_pcard2, load_pcard3;
  logic load_dcard1, load_dcard2, load_dcard3;
  logic player_win_light, dealer_win_light;
  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light
  );
  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light
  );
endinterface

// File: rtl/baccarat_controller_banker_rule.sv
// banker_rule: banker third-card decision from banker total and player third-card value
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] i_dscore,
  input  logic [3:0] i_value,
  output logic       o_draw
);
  // totals of 7 and above, including corrupt scores > 9, always stand
  assign o_draw = (i_dscore >= BANKER_STAND) ? 1'b0 :
                  (i_dscore <= 4'd2)         ? 1'b1 :
                  (i_dscore == 4'd3)         ? (i_value != 4'd8) :
                  (i_dscore == 4'd4)         ? (i_value >= 4'd2 && i_value <= 4'd7) :
                  (i_dscore == 4'd5)         ? (i_value >= 4'd4 && i_value <= 4'd7) :
                                               (i_value >= 4'd6 && i_value <= 4'd7);
endmodule

// File: rtl/baccarat_controller.sv
// baccarat_controller: sequences one Punto Banco round and drives the win lights
module baccarat_controller
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  baccarat_if.master bus
);
  state_t     r_state, w_next;
  loads_t     r_loads;
  logic       w_draw, w_done;
  logic [3:0] w_value;
  assign w_value = card_value(bus.pcard3);
  banker_rule u_banker (
    .i_dscore (bus.dscore),
    .i_value  (w_value),
    .o_draw   (w_draw)
  );
  always_comb begin
    w_next = DEAL_P1;
    case (r_state)
      DEAL_P1: w_next = DEAL_D1;
      DEAL_D1: w_next = DEAL_P2;
      DEAL_P2: w_next = DEAL_D2;
      DEAL_D2: w_next = CHECK1;
      CHECK1:  w_next = (bus.pscore >= NATURAL_MIN || bus.dscore >= NATURAL_MIN) ? DONE :
                        (bus.pscore <= PLAYER_DRAW_MAX) ? DEAL_P3 :
                        (bus.dscore <= PLAYER_DRAW_MAX) ? DEAL_D3 : DONE;
      DEAL_P3: w_next = CHECK2;
      CHECK2:  w_next = w_draw ? DEAL_D3 : DONE;
      DEAL_D3: w_next = DONE;
      DONE:    w_next = DONE;
      default: w_next = DEAL_P1;
    endcase
  end
  // strobes are registered from the next state so they stay a pure function of r_state
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state <= DEAL_P1;
      r_loads <= loads_of(DEAL_P1);
    end else begin
      r_state <= w_next;
      r_loads <= loads_of(w_next);
    end
  end
  assign w_done               = (r_state == DONE);
  assign bus.load_pcard1      = r_loads.p1;
  assign bus.load_pcard2      = r_loads.p2;
  assign bus.load_pcard3      = r_loads.p3;
  assign bus.load_dcard1      = r_loads.d1;
  assign bus.load_dcard2      = r_loads.d2;
  assign bus.load_dcard3      = r_loads.d3;
  assign bus.player_win_light = w_done && (bus.pscore >= bus.dscore);
  assign bus.dealer_win_light = w_done && (bus.dscore >= bus.pscore);
endmodule

// File: doc/baccarat_controller.md
Name: baccarat_controller

Overview:
- Control FSM for one Baccarat round; the counterpart of the card datapath.
- Sequences the six card-load strobes that the datapath consumes, and reads back pscore, dscore and pcard3 from the datapath.
- Applies the Punto Banco third-card rules and drives the player/dealer win lights.
- Sits beside the datapath in the top level; both run on slow_clock.

Parameters:
- none (all game rules are fixed constants in the shared package)

Ports:
- slow_clock  input  1  sole clock; all state updates on posedge
- resetb  input  1  asynchronous active-low reset
- pscore  input  4  player hand total 0..9, from datapath
- dscore  input  4  dealer hand total 0..9, from datapath
- pcard3  input  4  player third card rank: 0 = none, 1..13 = A..K
- load_pcard1, load_pcard2, load_pcard3  output  1 each  player card register load enables
- load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card register load enables
- player_win_light  output  1  player wins, or tie
- dealer_win_light  output  1  dealer wins, or tie

Behaviour:
- Clock and reset:
  - One clock, slow_clock.
  - resetb is asynchronous and active-low; the state goes to DEAL_P1 immediately on assertion, independent of the clock.
- Outputs are Moore: decoded from the current state only. At most one load strobe is high in any state.
- Each load strobe is sampled by the datapath on the same posedge that advances the FSM. The loaded card is therefore visible in pscore/dscore/pcard3 in the following state.
- States and transitions:
  - DEAL_P1 (load_pcard1=1) -> DEAL_D1
  - DEAL_D1 (load_dcard1=1) -> DEAL_P2
  - DEAL_P2 (load_pcard2=1) -> DEAL_D2
  - DEAL_D2 (load_dcard2=1) -> CHECK1
  - CHECK1, no loads:
    - pscore >= 8 or dscore >= 8 (natural) -> DONE
    - else pscore <= 5 -> DEAL_P3
    - else (player stands) dscore <= 5 -> DEAL_D3
    - else -> DONE
  - DEAL_P3 (load_pcard3=1) -> CHECK2
  - CHECK2, no loads: compute v = card value of pcard3 (rank >= 10 counts 0, otherwise the rank).
    - dscore 0..2 -> draw
    - dscore 3 -> draw unless v == 8
    - dscore 4 -> draw if v in 2..7
    - dscore 5 -> draw if v in 4..7
    - dscore 6 -> draw if v in 6..7
    - dscore 7 -> stand
    - draw -> DEAL_D3; stand -> DONE
  - DEAL_D3 (load_dcard3=1) -> DONE
  - DONE: terminal; holds until resetb is asserted. No strobes.
- Win lights:
  - High only in DONE.
  - pscore > dscore: player light only.
  - dscore > pscore: dealer light only.
  - Equal: both lights.
  - Lights follow the scores combinationally in DONE; scores are stable there.
- Reset values:
  - State DEAL_P1, so load_pcard1=1 while in reset; the datapath registers are held in reset at the same time.
  - All other loads = 0; both lights = 0.
  - The first card loads on the first posedge after resetb rises.
- Round length from reset release to DONE:
  - 5 edges (natural or no draw)
  - 6 edges (dealer-only draw)
  - 7 edges (player draws, banker stands)
  - 8 edges (both draw)
- Reset mid-round:
  - Immediate return to DEAL_P1; lights drop and stray strobes clear in the same cycle.
  - No partial-round state is retained.
- Illegal inputs:
  - A score > 9 is treated as >= 8 (natural) in CHECK1 and as stand in CHECK2.
  - pcard3 = 0 or 14..15 in CHECK2 is treated as v = 0.
- Unreachable state encodings recover to DEAL_P1 on the next edge.

Decomposition:
- Package baccarat_pkg:
  - state enum typedef
  - constants NATURAL_MIN=8, PLAYER_DRAW_MAX=5, BANKER_STAND=7
  - function card_value(rank) -> 0..9
- Sub-module banker_rule:
  - Combinational: inputs dscore and the pcard3 value; output draw.
  - Instantiated once and used by CHECK2.
  - Unit-testable exhaustively (10x10 cases).

Test Plan:
- Natural: cards P=4,5 and D=2,3 (pscore 9, dscore 5) -> loads strobe in order P1,D1,P2,D2; CHECK1 -> DONE; load_pcard3/load_dcard3 never high; player_win_light=1, dealer_win_light=0 on edge 5.
- Player stands, dealer draws: P=3,3 (6), D=A,2 (3), D3=4 (7) -> only load_dcard3 after CHECK1; DONE with dealer light only; 6 edges.
- Banker-6 rule: P=2,2 (4), P3=7, D=3,3 (6) -> CHECK2 draws D3. Rerun with P3=K (v=0) -> banker stands, no load_dcard3.
- Banker-3 exception: P=A,A (2), P3=8 (score 0), D=A,2 (3) -> banker stands; dealer light only (3 > 0).
- Tie: P=10,7 (7), D=3,4 (7) -> both stand; DONE with both lights=1.
- Async reset: drop resetb mid-cycle while in DEAL_D2 -> load_dcard2 falls and load_pcard1 rises without a clock edge; lights 0. After release, the full sequence restarts from DEAL_P1.
